// File: rtl/qpimem_iface_interleave_pkg.sv
// Shared constants and types for the dual-PSRAM QPI interleaved memory interface.
package qpimem_iface_interleave_pkg;

  localparam int READ_DUMMY = 6;

  localparam logic [7:0] OP_QPI_EN = 8'h35;
  localparam logic [7:0] OP_WRITE  = 8'h38;
  localparam logic [7:0] OP_READ   = 8'hEB;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_INIT_CMD,
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA_WR,
    ST_DATA_RD,
    ST_END
  } state_t;

  // Command/address nibbles go to both chips, so each bus byte carries the nibble twice.
  function automatic logic [7:0] dup_nib(input logic [3:0] n);
    return {n, n};
  endfunction

endpackage

// File: rtl/qpimem_iface_interleave_if.sv
// Host handshake plus the shared two-chip PSRAM bus.
interface qpimem_iface_interleave_if;
  logic        do_read;
  logic        do_write;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        next_word;
  logic        is_idle;
  logic        spi_clk;
  logic        spi_ncs;
  logic [3:0]  spi_sout_a;
  logic [3:0]  spi_sout_b;
  logic [3:0]  spi_sin_a;
  logic [3:0]  spi_sin_b;
  logic        spi_oe;
  logic        spi_bus_qpi;

  modport slave (
    input  do_read, do_write, addr, wdata, spi_sin_a, spi_sin_b,
    output rdata, next_word, is_idle, spi_clk, spi_ncs, spi_sout_a, spi_sout_b,
           spi_oe, spi_bus_qpi
  );

  modport master (
    output do_read, do_write, addr, wdata, spi_sin_a, spi_sin_b,
    input  rdata, next_word, is_idle, spi_clk, spi_ncs, spi_sout_a, spi_sout_b,
           spi_oe, spi_bus_qpi
  );
endinterface

// File: rtl/qpimem_iface_interleave_shift8.sv
// One byte per spi clock across two nibble lanes (A = high, B = low); SPI mode shifts 1 bit.
module qpimem_shift8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       step,
  input  logic       qpi,
  input  logic [3:0] sin_a,
  input  logic [3:0] sin_b,
  output logic [3:0] sout_a,
  output logic [3:0] sout_b,
  output logic [7:0] dout
);
  logic [7:0] sr;

  always_ff @(posedge clk) begin
    if (rst)       sr <= '0;
    else if (load) sr <= din;
    else if (step) sr <= qpi ? {sin_a, sin_b} : {sr[6:0], sin_a[1]};
  end

  // SPI mode drives MOSI on bit0 of both chips
  assign sout_a = qpi ? sr[7:4] : {3'b000, sr[7]};
  assign sout_b = qpi ? sr[3:0] : {3'b000, sr[7]};
  assign dout   = sr;
endmodule

// File: rtl/qpimem_iface_interleave.sv
// Word-burst host interface to two PSRAMs in QPI mode, interleaved by nibble (A high, B low).
module qpimem_iface_interleave #(
  parameter int READ_DUMMY = qpimem_iface_interleave_pkg::READ_DUMMY
) (
  input logic                        clk,
  input logic                        rst,
  qpimem_iface_interleave_if.slave   bus
);
  import qpimem_iface_interleave_pkg::*;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  bidx_q, bidx_d;
  logic        sclk_q, sclk_d;
  logic        ncs_q, ncs_d;
  logic        oe_q, oe_d;
  logic        qpi_q, qpi_d;
  logic        idle_q, idle_d;
  logic        nw_q, nw_d;
  logic        wr_q, wr_d;
  logic [23:0] caddr_q, caddr_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] rdacc_q, rdacc_d;
  logic [31:0] rdata_q, rdata_d;

  logic        sh_load, sh_step, wr_word, go_end;
  logic [7:0]  sh_din, sh_dout;

  qpimem_shift8 u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .din   (sh_din),
    .step  (sh_step),
    .qpi   (qpi_q),
    .sin_a (bus.spi_sin_a),
    .sin_b (bus.spi_sin_b),
    .sout_a(bus.spi_sout_a),
    .sout_b(bus.spi_sout_b),
    .dout  (sh_dout)
  );

  // Each spi clock is two clk: sclk_q=0 -> rising edge (sample), sclk_q=1 -> falling edge (advance).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    sclk_d  = sclk_q;
    ncs_d   = ncs_q;
    oe_d    = oe_q;
    qpi_d   = qpi_q;
    idle_d  = idle_q;
    nw_d    = 1'b0;
    wr_d    = wr_q;
    caddr_d = caddr_q;
    wbuf_d  = wbuf_q;
    rdacc_d = rdacc_q;
    rdata_d = rdata_q;
    sh_load = 1'b0;
    sh_step = 1'b0;
    sh_din  = '0;
    wr_word = 1'b0;
    go_end  = 1'b0;

    case (state_q)
      ST_RESET: begin
        ncs_d   = 1'b0;
        oe_d    = 1'b1;
        sh_load = 1'b1;
        sh_din  = OP_QPI_EN;
        cnt_d   = 8'd7;
        state_d = ST_INIT_CMD;
      end
      ST_INIT_CMD: begin
        sclk_d = ~sclk_q;
        if (sclk_q) begin
          if (cnt_q == 8'd0) begin
            go_end = 1'b1;
            qpi_d  = 1'b1;
          end else begin
            sh_step = 1'b1;
            cnt_d   = cnt_q - 8'd1;
          end
        end
      end
      ST_IDLE: begin
        if (bus.do_write || bus.do_read) begin
          wr_d    = bus.do_write;
          caddr_d = {1'b0, bus.addr[23:1]};
          ncs_d   = 1'b0;
          oe_d    = 1'b1;
          idle_d  = 1'b0;
          sh_load = 1'b1;
          sh_din  = dup_nib(bus.do_write ? OP_WRITE[7:4] : OP_READ[7:4]);
          cnt_d   = 8'd1;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        sclk_d = ~sclk_q;
        if (sclk_q) begin
          sh_load = 1'b1;
          if (cnt_q == 8'd0) begin
            sh_din  = dup_nib(caddr_q[23:20]);
            caddr_d = {caddr_q[19:0], 4'h0};
            cnt_d   = 8'd5;
            state_d = ST_ADDR;
          end else begin
            sh_din = dup_nib(wr_q ? OP_WRITE[3:0] : OP_READ[3:0]);
            cnt_d  = cnt_q - 8'd1;
          end
        end
      end
      ST_ADDR: begin
        sclk_d = ~sclk_q;
        if (sclk_q) begin
          if (cnt_q != 8'd0) begin
            sh_load = 1'b1;
            sh_din  = dup_nib(caddr_q[23:20]);
            caddr_d = {caddr_q[19:0], 4'h0};
            cnt_d   = cnt_q - 8'd1;
          end else if (wr_q) begin
            wr_word = 1'b1;
          end else begin
            oe_d    = 1'b0;
            cnt_d   = 8'(READ_DUMMY - 1);
            state_d = ST_DUMMY;
          end
        end
      end
      ST_DUMMY: begin
        sclk_d = ~sclk_q;
        if (sclk_q) begin
          if (cnt_q == 8'd0) begin
            bidx_d  = 2'd0;
            state_d = ST_DATA_RD;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_DATA_WR: begin
        sclk_d = ~sclk_q;
        if (sclk_q) begin
          if (bidx_q == 2'd3) begin
            wr_word = 1'b1;
          end else begin
            sh_load = 1'b1;
            sh_din  = wbuf_q[{bidx_q + 2'd1, 3'b000} +: 8];
            bidx_d  = bidx_q + 2'd1;
          end
        end
      end
      ST_DATA_RD: begin
        sclk_d = ~sclk_q;
        if (!sclk_q) begin
          sh_step = 1'b1;
        end else begin
          rdacc_d[{bidx_q, 3'b000} +: 8] = sh_dout;
          bidx_d = bidx_q + 2'd1;
          // A word the host no longer holds do_read for is dropped, not reported
          if (bidx_q == 2'd3) begin
            if (bus.do_read) begin
              rdata_d = {sh_dout, rdacc_q[23:0]};
              nw_d    = 1'b1;
            end else begin
              go_end = 1'b1;
            end
          end
        end
      end
      ST_END: begin
        sclk_d = 1'b0;
        if (cnt_q == 8'd0) begin
          idle_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_RESET;
    endcase

    if (wr_word) begin
      if (bus.do_write) begin
        wbuf_d  = bus.wdata;
        sh_load = 1'b1;
        sh_din  = bus.wdata[7:0];
        nw_d    = 1'b1;
        bidx_d  = 2'd0;
        state_d = ST_DATA_WR;
      end else begin
        go_end = 1'b1;
      end
    end

    // END keeps ncs high for two clk and parks the data lines at zero
    if (go_end) begin
      state_d = ST_END;
      ncs_d   = 1'b1;
      oe_d    = 1'b0;
      sclk_d  = 1'b0;
      cnt_d   = 8'd1;
      sh_load = 1'b1;
      sh_din  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      bidx_q  <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      oe_q    <= 1'b0;
      qpi_q   <= 1'b0;
      idle_q  <= 1'b0;
      nw_q    <= 1'b0;
      wr_q    <= 1'b0;
      caddr_q <= '0;
      wbuf_q  <= '0;
      rdacc_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      oe_q    <= oe_d;
      qpi_q   <= qpi_d;
      idle_q  <= idle_d;
      nw_q    <= nw_d;
      wr_q    <= wr_d;
      caddr_q <= caddr_d;
      wbuf_q  <= wbuf_d;
      rdacc_q <= rdacc_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.spi_clk     = sclk_q;
  assign bus.spi_ncs     = ncs_q;
  assign bus.spi_oe      = oe_q;
  assign bus.spi_bus_qpi = qpi_q;
  assign bus.is_idle     = idle_q;
  assign bus.next_word   = nw_q;
  assign bus.rdata       = rdata_q;
endmodule

// File: tb/tb_qpimem_iface_interleave.sv
// Bench: two behavioural PSRAM chips on the shared bus, table vectors plus random bursts vs a word-level memory.
module tb_qpimem_iface_interleave;
  localparam int RD = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qpimem_iface_interleave_if bus();
  qpimem_iface_interleave #(.READ_DUMMY(RD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, got, exp);
    end
  endtask

  // ---------------- two PSRAM chip models ----------------
  logic [7:0]  mem_a [int];
  logic [7:0]  mem_b [int];
  bit          chip_qpi;
  bit          prev_sclk;
  int          rise_cnt;
  logic [7:0]  sh_a, sh_b, opc, last_opc, init_a, init_b;
  logic [23:0] ca, last_ca;
  logic [3:0]  hold_a, hold_b;
  int          init_clks, lane_diff, sclk_viol, oe_viol;

  always @(negedge clk) begin
    int j;
    logic [7:0] ba, bb;
    if (rst) begin
      chip_qpi = 0; prev_sclk = 0; rise_cnt = 0; init_clks = 0;
      init_a = '0; init_b = '0; opc = '0;
      bus.spi_sin_a = '0; bus.spi_sin_b = '0;
    end else begin
      if (bus.spi_ncs && bus.spi_clk) sclk_viol++;
      if (!bus.spi_ncs && chip_qpi && opc == 8'hEB && rise_cnt >= 8 && bus.spi_oe) oe_viol++;
      if (bus.spi_ncs) begin
        if (rise_cnt > 0 && !chip_qpi) begin
          init_a = sh_a; init_b = sh_b; init_clks = rise_cnt;
          if (sh_a == 8'h35 && sh_b == 8'h35 && rise_cnt == 8) chip_qpi = 1;
        end
        rise_cnt = 0;
      end else if (bus.spi_clk && !prev_sclk) begin
        if (!chip_qpi) begin
          sh_a = {sh_a[6:0], bus.spi_sout_a[0]};
          sh_b = {sh_b[6:0], bus.spi_sout_b[0]};
        end else if (rise_cnt < 8) begin
          if (bus.spi_sout_a != bus.spi_sout_b) lane_diff++;
          if (rise_cnt < 2) opc = {opc[3:0], bus.spi_sout_a};
          else              ca  = {ca[19:0], bus.spi_sout_a};
          if (rise_cnt == 7) begin last_opc = opc; last_ca = ca; end
        end else if (opc == 8'h38) begin
          j = rise_cnt - 8;
          if (j % 2 == 0) begin
            hold_a = bus.spi_sout_a; hold_b = bus.spi_sout_b;
          end else begin
            mem_a[int'(ca) + j / 2] = {hold_a, bus.spi_sout_a};
            mem_b[int'(ca) + j / 2] = {hold_b, bus.spi_sout_b};
          end
        end
        rise_cnt++;
      end else if (!bus.spi_clk && prev_sclk && chip_qpi && opc == 8'hEB && rise_cnt >= 8 + RD) begin
        j  = rise_cnt - 8 - RD;
        ba = mem_a.exists(int'(ca) + j / 2) ? mem_a[int'(ca) + j / 2] : 8'h00;
        bb = mem_b.exists(int'(ca) + j / 2) ? mem_b[int'(ca) + j / 2] : 8'h00;
        bus.spi_sin_a = (j % 2 == 0) ? ba[7:4] : ba[3:0];
        bus.spi_sin_b = (j % 2 == 0) ? bb[7:4] : bb[3:0];
      end
      prev_sclk = bus.spi_clk;
    end
  end

  // ---------------- host-side tasks ----------------
  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (bus.is_idle) begin ok = 1; break; end
    end
    chk(nm, {31'b0, ok}, 32'd1);
  endtask

  task automatic wr_burst(input logic [23:0] a, input int n, input logic [7:0][31:0] w,
                          input bit both, output int pulses, output bit to);
    int drop_at;
    pulses = 0; to = 1; drop_at = -1;
    bus.addr = a; bus.wdata = w[0]; bus.do_write = 1'b1; bus.do_read = both;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (c == drop_at) begin bus.do_write = 1'b0; bus.do_read = 1'b0; end
      if (bus.next_word) begin
        pulses++;
        if (pulses < 8) bus.wdata = w[pulses];
        if (pulses == n) drop_at = c + 1;
      end
      if (drop_at >= 0 && c >= drop_at && bus.is_idle) begin to = 0; break; end
    end
    bus.do_write = 1'b0; bus.do_read = 1'b0;
  endtask

  task automatic rd_burst(input logic [23:0] a, input int n, output logic [7:0][31:0] got,
                          output int pulses, output bit to);
    got = '0; pulses = 0; to = 1;
    bus.addr = a; bus.do_read = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (bus.next_word) begin
        if (pulses < 8) got[pulses] = bus.rdata;
        pulses++;
        if (pulses >= n) bus.do_read = 1'b0;
      end
      if (!bus.do_read && bus.is_idle) begin to = 0; break; end
    end
    bus.do_read = 1'b0;
  endtask

  typedef struct {
    bit              wr;
    logic [23:0]     a;
    int              n;
    logic [7:0][31:0] w;
    logic [7:0]      care;
    logic [23:0]     exp_ca;
  } vec_t;

  logic [31:0] ref_mem [int];

  initial begin
    vec_t             tbl [3];
    logic [7:0][31:0] got, w;
    int               pulses, n, after;
    bit               to, ok;
    logic [23:0]      a;

    bus.do_read = 0; bus.do_write = 0; bus.addr = '0; bus.wdata = '0;
    lane_diff = 0; sclk_viol = 0; oe_viol = 0;

    tbl[0] = '{1'b1, 24'h001000, 3,
               {32'h0, 32'h0, 32'h0, 32'h0, 32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304},
               8'h07, 24'h000800};
    tbl[1] = '{1'b1, 24'h001010, 2,
               {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h15161718, 32'h11121314},
               8'h03, 24'h000808};
    tbl[2] = '{1'b0, 24'h001000, 6,
               {32'h0, 32'h0, 32'h15161718, 32'h11121314, 32'h0, 32'h090A0B0C, 32'h05060708, 32'h01020304},
               8'h37, 24'h000800};

    // reset state
    repeat (5) @(posedge clk);
    #1;
    chk("rst_ncs", {31'b0, bus.spi_ncs}, 32'd1);
    chk("rst_sclk", {31'b0, bus.spi_clk}, 32'd0);
    chk("rst_oe", {31'b0, bus.spi_oe}, 32'd0);
    chk("rst_qpi", {31'b0, bus.spi_bus_qpi}, 32'd0);
    chk("rst_nw_idle", {30'b0, bus.next_word, bus.is_idle}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_sout", {24'b0, bus.spi_sout_a, bus.spi_sout_b}, 32'd0);
    rst = 1'b0;

    // init sequence
    wait_idle("init_idle");
    chk("init_cmd_a", {24'b0, init_a}, 32'h35);
    chk("init_cmd_b", {24'b0, init_b}, 32'h35);
    chk("init_clks", init_clks, 32'd8);
    chk("init_qpi", {31'b0, bus.spi_bus_qpi}, 32'd1);

    // table vectors
    for (int i = 0; i < 3; i++) begin
      if (tbl[i].wr) begin
        wr_burst(tbl[i].a, tbl[i].n, tbl[i].w, 1'b0, pulses, to);
        chk($sformatf("t%0d_timeout", i), {31'b0, to}, 32'd0);
        chk($sformatf("t%0d_pulses", i), pulses, tbl[i].n);
        chk($sformatf("t%0d_opc", i), {24'b0, last_opc}, 32'h38);
        for (int k = 0; k < tbl[i].n; k++) ref_mem[int'(tbl[i].a) + 4 * k] = tbl[i].w[k];
      end else begin
        rd_burst(tbl[i].a, tbl[i].n, got, pulses, to);
        chk($sformatf("t%0d_timeout", i), {31'b0, to}, 32'd0);
        chk($sformatf("t%0d_pulses", i), pulses, tbl[i].n);
        chk($sformatf("t%0d_opc", i), {24'b0, last_opc}, 32'hEB);
        for (int k = 0; k < tbl[i].n; k++)
          if (tbl[i].care[k]) chk($sformatf("t%0d_word%0d", i, k), got[k], tbl[i].w[k]);
      end
      chk($sformatf("t%0d_caddr", i), {8'b0, last_ca}, {8'b0, tbl[i].exp_ca});
      chk($sformatf("t%0d_idle", i), {31'b0, bus.is_idle}, 32'd1);
    end

    // do_read and do_write together: write wins
    w = '0; w[0] = 32'hA5A55A5A;
    wr_burst(24'h003000, 1, w, 1'b1, pulses, to);
    chk("both_timeout", {31'b0, to}, 32'd0);
    chk("both_opc", {24'b0, last_opc}, 32'h38);
    chk("both_pulses", pulses, 32'd1);
    ref_mem[32'h3000] = w[0];

    // random bursts against the word-level reference
    for (int r = 0; r < 24; r++) begin
      a = 24'h002000 + 24'(4 * $urandom_range(0, 15));
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 8; k++) w[k] = $urandom;
        wr_burst(a, n, w, 1'b0, pulses, to);
        chk("rnd_wr_done", {31'b0, to}, 32'd0);
        chk("rnd_wr_pulses", pulses, n);
        for (int k = 0; k < n; k++) ref_mem[int'(a) + 4 * k] = w[k];
      end else begin
        rd_burst(a, n, got, pulses, to);
        chk("rnd_rd_done", {31'b0, to}, 32'd0);
        chk("rnd_rd_pulses", pulses, n);
        for (int k = 0; k < n; k++)
          if (ref_mem.exists(int'(a) + 4 * k))
            chk($sformatf("rnd_rd_%06h", int'(a) + 4 * k), got[k], ref_mem[int'(a) + 4 * k]);
      end
    end

    // reset in the middle of a read burst
    bus.addr = 24'h001000; bus.do_read = 1'b1; pulses = 0; ok = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (bus.next_word) pulses++;
      if (pulses == 2) begin ok = 1; break; end
    end
    chk("mid_rd_started", {31'b0, ok}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; bus.do_read = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ncs", {31'b0, bus.spi_ncs}, 32'd1);
    chk("mid_rst_rdata", bus.rdata, 32'd0);
    after = 0;
    repeat (4) begin @(posedge clk); #1; if (bus.next_word) after++; end
    rst = 1'b0;
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (bus.next_word) after++;
      if (bus.is_idle) begin ok = 1; break; end
    end
    chk("mid_rst_reinit", {31'b0, ok}, 32'd1);
    chk("mid_rst_no_pulse", after, 32'd0);
    chk("mid_rst_init_clks", init_clks, 32'd8);
    chk("mid_rst_qpi", {31'b0, bus.spi_bus_qpi}, 32'd1);

    chk("lanes_identical", lane_diff, 32'd0);
    chk("sclk_idle_low", sclk_viol, 32'd0);
    chk("oe_low_in_read", oe_viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
